// File: rtl/acondicionador_entradas_alarma.sv
// Input conditioning for the car alarm: synchronises and debounces the door, ignition
// and light push-button lines, and turns the debounced button into a toggling light level.
module acondicionador_entradas_alarma #(
    parameter int N_SYNC          = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic bLuz_raw,
    input  logic sPrta_raw,
    input  logic sIgn_raw,
    output logic sLuz,
    output logic sPrta,
    output logic sIgn,
    output logic pulso_luz
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Channel 0 = light button, 1 = door, 2 = ignition
    logic [2:0] w_raw;
    logic [2:0] w_sync;
    logic [2:0] w_deb;
    logic [2:0] w_accept;
    logic       r_luz;
    logic       r_pulso;

    assign w_raw = {sIgn_raw, sPrta_raw, bLuz_raw};

    for (genvar g = 0; g < 3; g++) begin : g_chan
        logic [N_SYNC-1:0] r_sync;
        logic [CNT_W-1:0]  r_cnt;
        logic              r_deb;
        logic              w_s;

        assign w_s         = r_sync[N_SYNC-1];
        assign w_accept[g] = (w_s != r_deb) && (r_cnt == CNT_MAX);
        assign w_sync[g]   = w_s;
        assign w_deb[g]    = r_deb;

        // Any sample matching the accepted level discards all progress toward a change
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync <= '0;
                r_cnt  <= '0;
                r_deb  <= 1'b0;
            end else begin
                r_sync <= {r_sync[N_SYNC-2:0], w_raw[g]};
                if (w_s == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_MAX) begin
                    r_deb <= w_s;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end
    end

    // Only an accepted press toggles the light; the release is debounced but ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_luz   <= 1'b0;
            r_pulso <= 1'b0;
        end else begin
            r_pulso <= 1'b0;
            if (w_accept[0] && w_sync[0]) begin
                r_luz   <= ~r_luz;
                r_pulso <= 1'b1;
            end
        end
    end

    assign sLuz      = r_luz;
    assign pulso_luz = r_pulso;
    assign sPrta     = w_deb[1];
    assign sIgn      = w_deb[2];

endmodule

// File: tb/tb_acondicionador_entradas_alarma.sv
// Self-checking bench: directed scenarios plus random bouncy inputs, compared every
// cycle against a run-length reference model of the debounce rules.
module tb_acondicionador_entradas_alarma;

    localparam int NS = 2;
    localparam int DC = 4;
    localparam int LAT = NS + DC - 1;

    logic clk;
    logic reset;
    logic bLuz_raw;
    logic sPrta_raw;
    logic sIgn_raw;
    logic sLuz;
    logic sPrta;
    logic sIgn;
    logic pulso_luz;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: delay line for synchroniser latency, window of recent samples
    bit dl[3][NS];
    bit win[3][DC];
    bit mDeb[3];
    bit mLuz;
    bit mPulso;

    acondicionador_entradas_alarma #(
        .N_SYNC(NS),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bLuz_raw(bLuz_raw),
        .sPrta_raw(sPrta_raw),
        .sIgn_raw(sIgn_raw),
        .sLuz(sLuz),
        .sPrta(sPrta),
        .sIgn(sIgn),
        .pulso_luz(pulso_luz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < NS; k++) dl[c][k] = 1'b0;
            for (int k = 0; k < DC; k++) win[c][k] = 1'b0;
            mDeb[c] = 1'b0;
        end
        mLuz   = 1'b0;
        mPulso = 1'b0;
    endtask

    // A level is accepted once the last DC synchronised samples all disagree with the current one
    task automatic modelEdge(input bit b, input bit p, input bit i);
        bit raw[3];
        bit s;
        bit allDiff;
        raw[0] = b;
        raw[1] = p;
        raw[2] = i;
        mPulso = 1'b0;
        for (int c = 0; c < 3; c++) begin
            s = dl[c][0];
            for (int k = 0; k < NS - 1; k++) dl[c][k] = dl[c][k+1];
            dl[c][NS-1] = raw[c];
            for (int k = 0; k < DC - 1; k++) win[c][k] = win[c][k+1];
            win[c][DC-1] = s;
            allDiff = 1'b1;
            for (int k = 0; k < DC; k++) if (win[c][k] == mDeb[c]) allDiff = 1'b0;
            if (allDiff) begin
                mDeb[c] = s;
                if (c == 0 && s) begin
                    mLuz   = ~mLuz;
                    mPulso = 1'b1;
                end
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("sLuz", 32'(sLuz), 32'(mLuz));
        checkOutput("sPrta", 32'(sPrta), 32'(mDeb[1]));
        checkOutput("sIgn", 32'(sIgn), 32'(mDeb[2]));
        checkOutput("pulso_luz", 32'(pulso_luz), 32'(mPulso));
    endtask

    // Called at a negedge; drives inputs, lets one rising edge pass, checks, returns at next negedge
    task automatic applyStimulus(input bit b, input bit p, input bit i);
        bLuz_raw  = b;
        sPrta_raw = p;
        sIgn_raw  = i;
        @(posedge clk);
        modelEdge(b, p, i);
        #1;
        checkAll();
        @(negedge clk);
    endtask

    task automatic doReset(input int holdCycles);
        #1 reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        repeat (holdCycles) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int riseStep;
        int fallStep;
        int riseIgn;
        int pulses;
        bit sawIgn;
        bit curB;
        bit curP;
        bit curI;
        bit bouncy[9];

        reset     = 1'b1;
        bLuz_raw  = 1'b0;
        sPrta_raw = 1'b0;
        sIgn_raw  = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkAll();
        reset = 1'b0;

        riseStep = -1;
        for (int s = 1; s <= 10; s++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (sPrta === 1'b1 && riseStep < 0) riseStep = s;
        end
        checkOutput("door_latency", 32'(riseStep), 32'(1 + LAT));

        applyStimulus(1'b0, 1'b0, 1'b0);
        doReset(2);
        sawIgn = 1'b0;
        for (int s = 1; s <= 14; s++) begin
            applyStimulus(1'b0, 1'b0, s <= DC - 1);
            if (sIgn === 1'b1) sawIgn = 1'b1;
        end
        checkOutput("ign_glitch3", 32'(sawIgn), 32'd0);

        riseStep = -1;
        fallStep = -1;
        for (int s = 1; s <= 16; s++) begin
            applyStimulus(1'b0, 1'b0, s <= DC);
            if (sIgn === 1'b1 && riseStep < 0) riseStep = s;
            if (sIgn === 1'b0 && riseStep > 0 && fallStep < 0) fallStep = s;
        end
        checkOutput("ign_pulse4_rise", 32'(riseStep), 32'(1 + LAT));
        checkOutput("ign_pulse4_fall", 32'(fallStep), 32'(DC + 1 + LAT));

        doReset(1);
        bouncy = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
        riseStep = -1;
        for (int s = 0; s < 16; s++) begin
            applyStimulus(1'b0, (s < 9) ? bouncy[s] : 1'b1, 1'b0);
            if (sPrta === 1'b1 && riseStep < 0) riseStep = s;
        end
        checkOutput("door_bouncy", 32'(riseStep), 32'(5 + LAT));

        doReset(1);
        pulses = 0;
        for (int s = 0; s < 40; s++) begin
            applyStimulus((s < 10) || (s >= 20 && s < 30), 1'b0, 1'b0);
            if (pulso_luz === 1'b1) pulses++;
            if (s == 19) checkOutput("luz_after_press1", 32'(sLuz), 32'd1);
        end
        checkOutput("luz_pulses", 32'(pulses), 32'd2);
        checkOutput("luz_final", 32'(sLuz), 32'd0);

        doReset(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        doReset(2);
        riseStep = -1;
        for (int s = 0; s < 10; s++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            if (sIgn === 1'b1 && riseStep < 0) riseStep = s;
        end
        checkOutput("ign_after_reset", 32'(riseStep), 32'(LAT));

        applyStimulus(1'b0, 1'b0, 1'b0);
        doReset(1);
        riseStep = -1;
        riseIgn  = -1;
        for (int s = 0; s < 10; s++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (sPrta === 1'b1 && riseStep < 0) riseStep = s;
            if (sIgn === 1'b1 && riseIgn < 0) riseIgn = s;
        end
        checkOutput("simul_door", 32'(riseStep), 32'(LAT));
        checkOutput("simul_ign", 32'(riseIgn), 32'(LAT));

        curB = 1'b0;
        curP = 1'b1;
        curI = 1'b1;
        for (int s = 0; s < 2000; s++) begin
            if ($urandom_range(0, 3) == 0) curB = ~curB;
            if ($urandom_range(0, 4) == 0) curP = ~curP;
            if ($urandom_range(0, 5) == 0) curI = ~curI;
            if ($urandom_range(0, 199) == 0) doReset($urandom_range(0, 2));
            applyStimulus(curB, curP, curI);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
